// File: rtl/tnn_pkg.sv
// Shared types, constants and the saturating quantiser for the TNN feature loader.
// Used by the RTL and by the bench.
package tnn_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  localparam int N_FEAT = 4;

  localparam logic [1:0] FEAT_A    = 2'd0;
  localparam logic [1:0] FEAT_B    = 2'd1;
  localparam logic [1:0] FEAT_C    = 2'd2;
  localparam logic [1:0] FEAT_D    = 2'd3;
  localparam logic [1:0] FEAT_LAST = 2'(N_FEAT - 1);

  localparam int IN_W_DEF  = 8;
  localparam int Q_W_DEF   = 3;
  localparam int SHIFT_DEF = 5;
  localparam int ID_W_DEF  = 8;
  localparam int ERR_W_DEF = 8;

  // Right-shift then clamp to the largest value representable in q_w bits.
  function automatic logic [31:0] sat_quant(input logic [31:0] raw,
                                            input int          shift,
                                            input int          q_w);
    logic [31:0] q;
    logic [31:0] max_q;
    q     = raw >> shift;
    max_q = (32'd1 << q_w) - 32'd1;
    return (q > max_q) ? max_q : q;
  endfunction

endpackage

// File: rtl/tnn_feature_loader_if.sv
// Raw-feature input stream and tagged-result output stream of the loader.
// slave is the loader's view; master is the upstream/downstream view.
interface tnn_feature_loader_if
  import tnn_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int ID_W = ID_W_DEF
);

  logic            s_valid;
  logic            s_ready;
  logic [IN_W-1:0] s_data;
  logic            s_last;

  logic            res_valid;
  logic            res_ready;
  logic            res_bit;
  logic [ID_W-1:0] res_id;

  modport master (
    output s_valid, s_data, s_last, res_ready,
    input  s_ready, res_valid, res_bit, res_id
  );

  modport slave (
    input  s_valid, s_data, s_last, res_ready,
    output s_ready, res_valid, res_bit, res_id
  );

endinterface

// File: rtl/tnn_quantizer.sv
// Combinational shift-and-saturate of one raw feature down to Q_W bits.
module tnn_quantizer
  import tnn_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int Q_W   = Q_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic [IN_W-1:0] raw,
  output logic [Q_W-1:0]  q
);

  assign q = Q_W'(sat_quant(32'(raw), SHIFT, Q_W));

endmodule

// File: rtl/tnn_feature_loader.sv
// Assembles quantised feature groups for one TNN classifier node and returns its
// decision, tagged with a sample ID, over a valid/ready result stream.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_LOAD   | accepting raw beats into feat_a..feat_d, checking framing
//   ST_EVAL   | one cycle, features stable, node decision settles
//   ST_RESULT | result held on res_* until downstream accepts it
module tnn_feature_loader
  import tnn_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int Q_W   = Q_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int ID_W  = ID_W_DEF,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  tnn_feature_loader_if.slave bus,
  output logic [Q_W-1:0]    feat_a,
  output logic [Q_W-1:0]    feat_b,
  output logic [Q_W-1:0]    feat_c,
  output logic [Q_W-1:0]    feat_d,
  input  logic              cls_in,
  output logic              frame_err,
  output logic [ERR_W-1:0]  err_cnt
);

  state_t          state;
  logic [1:0]      cnt;
  logic            s_ready_q;
  logic            res_valid_q;
  logic            res_bit_q;
  logic [ID_W-1:0] res_id_q;
  logic [ID_W-1:0] sample_id;
  logic [Q_W-1:0]  q;
  logic            accept;

  tnn_quantizer #(
    .IN_W  (IN_W),
    .Q_W   (Q_W),
    .SHIFT (SHIFT)
  ) u_quant (
    .raw (bus.s_data),
    .q   (q)
  );

  assign accept        = bus.s_valid & s_ready_q;
  assign bus.s_ready   = s_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_bit   = res_bit_q;
  assign bus.res_id    = res_id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_LOAD;
      cnt         <= FEAT_A;
      feat_a      <= '0;
      feat_b      <= '0;
      feat_c      <= '0;
      feat_d      <= '0;
      s_ready_q   <= 1'b1;
      res_valid_q <= 1'b0;
      res_bit_q   <= 1'b0;
      res_id_q    <= '0;
      sample_id   <= '0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            case (cnt)
              FEAT_A:  feat_a <= q;
              FEAT_B:  feat_b <= q;
              FEAT_C:  feat_c <= q;
              default: feat_d <= q;
            endcase
            if (cnt == FEAT_LAST && bus.s_last) begin
              state     <= ST_EVAL;
              s_ready_q <= 1'b0;
              cnt       <= FEAT_A;
            end else if (cnt == FEAT_LAST || bus.s_last) begin
              // Misframed sample: drop it and resynchronise on the next beat.
              frame_err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
              cnt       <= FEAT_A;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        ST_EVAL: begin
          res_bit_q   <= cls_in;
          res_id_q    <= sample_id;
          res_valid_q <= 1'b1;
          state       <= ST_RESULT;
        end
        ST_RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            sample_id   <= sample_id + ID_W'(1);
            s_ready_q   <= 1'b1;
            state       <= ST_LOAD;
          end
        end
        default: begin
          state     <= ST_LOAD;
          s_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_feature_loader.sv
// Randomised and directed bench for tnn_feature_loader against a frame-level model.
module tb_tnn_feature_loader;
  import tnn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tnn_feature_loader_if #(.IN_W(8), .ID_W(8)) bus ();
  tnn_feature_loader_if #(.IN_W(8), .ID_W(8)) bus4 ();

  logic [2:0] fa, fb, fc, fd;
  logic [2:0] ga, gb, gc, gd;
  logic       ferr, ferr4;
  logic [7:0] ecnt, ecnt4;

  tnn_feature_loader #(.IN_W(8), .Q_W(3), .SHIFT(5), .ID_W(8), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .feat_a(fa), .feat_b(fb), .feat_c(fc), .feat_d(fd),
    .cls_in(fb[2]), .frame_err(ferr), .err_cnt(ecnt)
  );

  tnn_feature_loader #(.IN_W(8), .Q_W(3), .SHIFT(4), .ID_W(8), .ERR_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .feat_a(ga), .feat_b(gb), .feat_c(gc), .feat_d(gd),
    .cls_in(gb[2]), .frame_err(ferr4), .err_cnt(ecnt4)
  );

  int n_pass = 0;
  int n_total = 0;
  bit started = 1'b0;
  bit rr_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- frame-level reference model (SHIFT=5 instance) ----------------
  function automatic int mq(input int v, input int sh);
    int r;
    r = v / (1 << sh);
    return (r > 7) ? 7 : r;
  endfunction

  int         m_cnt;
  logic [2:0] m_feat [4];
  bit         m_pend;
  int         m_age;
  logic       m_rbit;
  logic [7:0] m_rid;
  logic [7:0] m_id;
  bit         m_ferr;
  int         m_err;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0;
      for (int i = 0; i < 4; i++) m_feat[i] = 3'd0;
      m_pend = 1'b0; m_age = 0; m_rbit = 1'b0; m_rid = 8'd0;
      m_id = 8'd0; m_ferr = 1'b0; m_err = 0;
    end else begin
      m_ferr = 1'b0;
      if (m_pend) begin
        if (m_age == 0) m_age = 1;
        else if (bus.res_ready) begin
          m_pend = 1'b0;
          m_id   = m_id + 8'd1;
        end
      end else if (bus.s_valid) begin
        m_feat[m_cnt] = 3'(mq(int'(bus.s_data), 5));
        m_cnt++;
        if (bus.s_last || m_cnt == 4) begin
          if (bus.s_last && m_cnt == 4) begin
            m_pend = 1'b1; m_age = 0;
            m_rbit = m_feat[1][2];
            m_rid  = m_id;
          end else begin
            m_ferr = 1'b1;
            if (m_err < 255) m_err++;
          end
          m_cnt = 0;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("s_ready",   32'(bus.s_ready),   32'(!m_pend));
      chk("res_valid", 32'(bus.res_valid), 32'(m_pend && m_age == 1));
      if (m_pend && m_age == 1) begin
        chk("res_bit", 32'(bus.res_bit), 32'(m_rbit));
        chk("res_id",  32'(bus.res_id),  32'(m_rid));
      end
      chk("feat_vec",  {20'd0, fa, fb, fc, fd}, {20'd0, m_feat[0], m_feat[1], m_feat[2], m_feat[3]});
      chk("frame_err", 32'(ferr), 32'(m_ferr));
      chk("err_cnt",   32'(ecnt), 32'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    if (rr_rand) bus.res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l;
    while (bus.s_ready !== 1'b1 && guard < 100) begin tick(); guard++; end
    if (guard >= 100) begin
      n_total++;
      $display("FAIL beat_timeout: s_ready=%b, expected 1", bus.s_ready);
    end
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic send_beat4(input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    bus4.s_valid = 1'b1; bus4.s_data = d; bus4.s_last = l;
    while (bus4.s_ready !== 1'b1 && guard < 100) begin tick(); guard++; end
    if (guard >= 100) begin
      n_total++;
      $display("FAIL beat4_timeout: s_ready=%b, expected 1", bus4.s_ready);
    end
    tick();
    bus4.s_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
    send_beat(d0, 1'b0);
    send_beat(d1, 1'b0);
    send_beat(d2, 1'b0);
    send_beat(d3, 1'b1);
  endtask

  task automatic wait_result(output logic b, output logic [7:0] id);
    int guard;
    guard = 0;
    while (bus.res_valid !== 1'b1 && guard < 100) begin tick(); guard++; end
    if (guard >= 100) begin
      n_total++;
      $display("FAIL result_timeout: res_valid=%b, expected 1", bus.res_valid);
    end
    b  = bus.res_bit;
    id = bus.res_id;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic       b;
    logic [7:0] id;
    int         kind, nb;

    rst = 1'b1;
    bus.s_valid = 1'b0;  bus.s_data = 8'd0;  bus.s_last = 1'b0;  bus.res_ready = 1'b1;
    bus4.s_valid = 1'b0; bus4.s_data = 8'd0; bus4.s_last = 1'b0; bus4.res_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    started = 1'b1;

    chk("rst_feat",    {20'd0, fa, fb, fc, fd}, 32'd0);
    chk("rst_valid",   32'(bus.res_valid), 32'd0);
    chk("rst_ready",   32'(bus.s_ready),   32'd1);
    chk("rst_err_cnt", 32'(ecnt),          32'd0);
    chk("rst_res_id",  32'(bus.res_id),    32'd0);

    // Basic sample and latency
    send_sample(8'h20, 8'h40, 8'hFF, 8'h00);
    chk("s1_feat", {20'd0, fa, fb, fc, fd}, {20'd0, 3'd1, 3'd2, 3'd7, 3'd0});
    chk("lat_t1_valid", 32'(bus.res_valid), 32'd0);
    tick();
    chk("lat_t2_valid", 32'(bus.res_valid), 32'd1);
    chk("s1_res_bit",   32'(bus.res_bit),   32'd0);
    chk("s1_res_id",    32'(bus.res_id),    32'd0);
    tick();
    chk("lat_t3_ready", 32'(bus.s_ready),   32'd1);

    // Two identical samples with feat_b[2]=1
    do_reset();
    send_sample(8'h80, 8'hA0, 8'h00, 8'h00);
    wait_result(b, id);
    chk("s2a_bit", 32'(b), 32'd1);
    chk("s2a_id",  32'(id), 32'd0);
    send_sample(8'h80, 8'hA0, 8'h00, 8'h00);
    wait_result(b, id);
    chk("s2b_bit", 32'(b), 32'd1);
    chk("s2b_id",  32'(id), 32'd1);
    tick();

    // Short frame: s_last on the 2nd beat
    do_reset();
    send_beat(8'h20, 1'b0);
    send_beat(8'h40, 1'b1);
    chk("ferr_pulse", 32'(ferr), 32'd1);
    chk("ferr_cnt",   32'(ecnt), 32'd1);
    tick();
    chk("ferr_clear", 32'(ferr), 32'd0);
    repeat (3) tick();
    chk("ferr_no_result", 32'(bus.res_valid), 32'd0);
    send_sample(8'h20, 8'h40, 8'hFF, 8'h00);
    wait_result(b, id);
    chk("ferr_next_id", 32'(id), 32'd0);
    tick();

    // Reset at count=2, then with a result pending
    send_beat(8'h80, 1'b0);
    send_beat(8'hA0, 1'b0);
    do_reset();
    chk("rst2_feat", {20'd0, fa, fb, fc, fd}, 32'd0);
    chk("rst2_err",  32'(ecnt), 32'd0);
    send_sample(8'h20, 8'h40, 8'hFF, 8'h00);
    wait_result(b, id);
    tick();
    bus.res_ready = 1'b0;
    send_sample(8'h80, 8'hA0, 8'h00, 8'h00);
    wait_result(b, id);
    chk("pend_id", 32'(id), 32'd1);
    do_reset();
    chk("rst3_out", {29'd0, bus.res_valid, bus.res_bit, ferr}, 32'd0);
    chk("rst3_id",  32'(bus.res_id), 32'd0);
    bus.res_ready = 1'b1;
    send_sample(8'h20, 8'h40, 8'hFF, 8'h00);
    wait_result(b, id);
    chk("rst3_next_id", 32'(id), 32'd0);
    tick();

    // Backpressure: hold res_ready low for 10 cycles
    bus.res_ready = 1'b0;
    send_sample(8'h80, 8'hA0, 8'h00, 8'h00);
    wait_result(b, id);
    chk("hold_bit0", 32'(b), 32'd1);
    chk("hold_id0",  32'(id), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_stable", {22'd0, bus.s_ready, bus.res_valid, bus.res_bit, bus.res_id},
                         {22'd0, 1'b0, 1'b1, b, id});
      tick();
    end
    bus.res_ready = 1'b1;
    chk("hold_c11_valid", 32'(bus.res_valid), 32'd1);
    tick();
    chk("hold_after_ready", 32'(bus.s_ready),   32'd1);
    chk("hold_after_valid", 32'(bus.res_valid), 32'd0);

    // SHIFT=4 instance with saturation
    send_beat4(8'hFF, 1'b0);
    send_beat4(8'h3F, 1'b0);
    send_beat4(8'h10, 1'b0);
    send_beat4(8'h70, 1'b1);
    chk("sh4_feat", {20'd0, ga, gb, gc, gd}, {20'd0, 3'd7, 3'd3, 3'd1, 3'd7});
    chk("sh4_ferr", {23'd0, ferr4, ecnt4}, 32'd0);
    tick();

    // Error counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) send_beat(8'($urandom_range(0, 255)), 1'b1);
    chk("err_saturate", 32'(ecnt), 32'd255);

    // ID wrap over 257 samples
    do_reset();
    for (int k = 0; k < 257; k++) begin
      send_sample(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_result(b, id);
      if (k == 255) chk("wrap_last_id", 32'(id), 32'd255);
      if (k == 256) chk("wrap_next_id", 32'(id), 32'd0);
    end
    tick();

    // Random framing, gaps and backpressure
    do_reset();
    rr_rand = 1'b1;
    for (int s = 0; s < 80; s++) begin
      kind = int'($urandom_range(0, 5));
      nb   = (kind == 4) ? int'($urandom_range(1, 3)) : 4;
      for (int bi = 0; bi < nb; bi++) begin
        repeat ($urandom_range(0, 1)) tick();
        send_beat(8'($urandom_range(0, 255)), (kind == 5) ? 1'b0 : (bi == nb - 1));
      end
    end
    rr_rand = 1'b0;
    bus.res_ready = 1'b1;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
